seq_control_unit: RTL and testbench

SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/lsb_encoder.sv | 24 ++
 rtl/seq_control_unit.sv | 169 ++++++++++++++++
 tb/tb_seq_control_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode constants, ALU command encodings and the sequencer state type
// for the sequencing control unit.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        BLOCK    = 2'd2
    } state_e;

    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;
    localparam logic [1:0] MODE_BLK = 2'b11;

    // Instruction opcode field values
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;

    // ALU command encodings driven on EXE_CMD
    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       wb_en;
    } alu_dec_t;

    // CMP/TST reuse the SUB/AND datapath but only update flags.
    function automatic alu_dec_t alu_decode(input logic [3:0] op);
        alu_dec_t d;
        case (op)
            OP_MOV:  d = '{exe_cmd: EXE_MOV, wb_en: 1'b1};
            OP_MVN:  d = '{exe_cmd: EXE_MVN, wb_en: 1'b1};
            OP_ADD:  d = '{exe_cmd: EXE_ADD, wb_en: 1'b1};
            OP_ADC:  d = '{exe_cmd: EXE_ADC, wb_en: 1'b1};
            OP_SUB:  d = '{exe_cmd: EXE_SUB, wb_en: 1'b1};
            OP_SBC:  d = '{exe_cmd: EXE_SBC, wb_en: 1'b1};
            OP_AND:  d = '{exe_cmd: EXE_AND, wb_en: 1'b1};
            OP_ORR:  d = '{exe_cmd: EXE_ORR, wb_en: 1'b1};
            OP_EOR:  d = '{exe_cmd: EXE_EOR, wb_en: 1'b1};
            OP_CMP:  d = '{exe_cmd: EXE_SUB, wb_en: 1'b0};
            OP_TST:  d = '{exe_cmd: EXE_AND, wb_en: 1'b0};
            default: d = '{exe_cmd: EXE_NOP, wb_en: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsb_encoder.sv
// Priority encoder returning the index of the lowest set bit of a mask,
// with a flag telling whether any bit is set.
module lsb_encoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [NUM_REGS-1:0]         mask,
    output logic [$clog2(NUM_REGS)-1:0] idx,
    output logic                        valid
);
    localparam int IW = $clog2(NUM_REGS);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_control_unit.sv
// Decode-stage control unit: same-cycle ALU/branch decode, single memory
// accesses that wait on the cache, and multi-beat block transfers.
module seq_control_unit
    import ctrl_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int WORD_BYTES = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         instr_valid,
    input  logic [3:0]                                   opcode,
    input  logic [1:0]                                   mode,
    input  logic                                         S_IN,
    input  logic [NUM_REGS-1:0]                          reg_list,
    input  logic                                         mem_ready,
    output logic [3:0]                                   EXE_CMD,
    output logic                                         writeBackEn,
    output logic                                         MEM_R_en,
    output logic                                         MEM_W_en,
    output logic                                         b,
    output logic                                         S,
    output logic                                         stall,
    output logic [$clog2(NUM_REGS)-1:0]                  xfer_reg,
    output logic [$clog2(NUM_REGS*WORD_BYTES):0]         addr_offset,
    output logic                                         done,
    output state_e                                       state_dbg
);
    localparam int IW = $clog2(NUM_REGS);
    localparam int AW = $clog2(NUM_REGS * WORD_BYTES) + 1;
    localparam int CW = $clog2(NUM_REGS) + 1;

    state_e              state_q, state_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                s_q, s_d;
    logic [IW-1:0]       lsb_idx;
    logic                lsb_valid;
    alu_dec_t            dec;

    lsb_encoder #(.NUM_REGS(NUM_REGS)) u_lsb (
        .mask  (mask_q),
        .idx   (lsb_idx),
        .valid (lsb_valid)
    );

    assign dec       = alu_decode(opcode);
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        EXE_CMD     = EXE_NOP;
        writeBackEn = 1'b0;
        MEM_R_en    = 1'b0;
        MEM_W_en    = 1'b0;
        b           = 1'b0;
        S           = 1'b0;
        stall       = 1'b0;
        xfer_reg    = '0;
        addr_offset = '0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    case (mode)
                        MODE_ALU: begin
                            EXE_CMD     = dec.exe_cmd;
                            writeBackEn = dec.wb_en;
                            S           = S_IN;
                        end
                        MODE_BR: b = 1'b1;
                        MODE_MEM: begin
                            EXE_CMD     = EXE_ADD;
                            MEM_R_en    = S_IN;
                            MEM_W_en    = !S_IN;
                            writeBackEn = S_IN;
                            if (mem_ready) begin
                                done = 1'b1;
                            end else begin
                                stall   = 1'b1;
                                s_d     = S_IN;
                                state_d = MEM_WAIT;
                            end
                        end
                        default: begin
                            // Block transfer: the first beat is issued from BLOCK,
                            // so mem_ready in this cycle is deliberately ignored.
                            if (reg_list == '0) begin
                                done = 1'b1;
                            end else begin
                                stall   = 1'b1;
                                mask_d  = reg_list;
                                s_d     = S_IN;
                                cnt_d   = '0;
                                state_d = BLOCK;
                            end
                        end
                    endcase
                end
            end
            MEM_WAIT: begin
                EXE_CMD     = EXE_ADD;
                MEM_R_en    = s_q;
                MEM_W_en    = !s_q;
                writeBackEn = s_q;
                if (mem_ready) begin
                    done    = 1'b1;
                    s_d     = 1'b0;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            BLOCK: begin
                stall       = 1'b1;
                EXE_CMD     = EXE_ADD;
                MEM_R_en    = s_q;
                MEM_W_en    = !s_q;
                writeBackEn = s_q;
                xfer_reg    = lsb_idx;
                addr_offset = AW'(cnt_q) * AW'(WORD_BYTES);
                if (!lsb_valid) begin
                    state_d = IDLE;
                end else if (mem_ready) begin
                    mask_d[lsb_idx] = 1'b0;
                    cnt_d           = cnt_q + CW'(1);
                    if (mask_d == '0) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        s_d     = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset silences every output immediately, not just at the next edge.
        if (!rst) begin
            EXE_CMD     = EXE_NOP;
            writeBackEn = 1'b0;
            MEM_R_en    = 1'b0;
            MEM_W_en    = 1'b0;
            b           = 1'b0;
            S           = 1'b0;
            stall       = 1'b0;
            xfer_reg    = '0;
            addr_offset = '0;
            done        = 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed self-checking bench for seq_control_unit with default parameters.
module tb_seq_control_unit;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [1:0]  mode;
    logic        S_IN;
    logic [15:0] reg_list;
    logic        mem_ready;
    logic [3:0]  EXE_CMD;
    logic        writeBackEn, MEM_R_en, MEM_W_en, b, S, stall, done;
    logic [3:0]  xfer_reg;
    logic [6:0]  addr_offset;
    state_e      state_dbg;

    // Control bundle: {EXE_CMD, writeBackEn, MEM_R_en, MEM_W_en, b, S, stall, done}
    logic [10:0] ctl;
    assign ctl = {EXE_CMD, writeBackEn, MEM_R_en, MEM_W_en, b, S, stall, done};

    int checks   = 0;
    int failures = 0;

    seq_control_unit #(.NUM_REGS(16), .WORD_BYTES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .mode        (mode),
        .S_IN        (S_IN),
        .reg_list    (reg_list),
        .mem_ready   (mem_ready),
        .EXE_CMD     (EXE_CMD),
        .writeBackEn (writeBackEn),
        .MEM_R_en    (MEM_R_en),
        .MEM_W_en    (MEM_W_en),
        .b           (b),
        .S           (S),
        .stall       (stall),
        .xfer_reg    (xfer_reg),
        .addr_offset (addr_offset),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; instr_valid = 1'b1; mode = MODE_MEM; S_IN = 1'b1;
        opcode = 4'b0100; reg_list = 16'hFFFF; mem_ready = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (ctl !== 11'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 11'b0); end
        checks++;
        if ({xfer_reg, addr_offset} !== 11'b0) begin failures++; $display("FAIL reset_xfer got=%h/%h exp=0/0", xfer_reg, addr_offset); end
        checks++;
        if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
        tick();
        rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 11'b0) begin failures++; $display("FAIL idle_novalid got=%b exp=%b", ctl, 11'b0); end
        tick();
    endtask

    task automatic test_alu();
        logic [3:0] ops [12];
        logic [3:0] exes [12];
        logic       wbs [12];
        logic       sins [12];
        logic [10:0] exp;
        ops  = '{4'b0100, 4'b0011, 4'b1101, 4'b1111, 4'b0101, 4'b0010,
                 4'b0110, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000};
        exes = '{4'b0010, 4'b0000, 4'b0001, 4'b1001, 4'b0011, 4'b0100,
                 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b0100, 4'b0110};
        wbs  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        sins = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            instr_valid = 1'b1; mode = MODE_ALU; opcode = ops[i]; S_IN = sins[i];
            mem_ready = 1'b0; reg_list = 16'h1234;
            exp = {exes[i], wbs[i], 3'b000, sins[i], 2'b00};
            @(negedge clk);
            checks++;
            if (ctl !== exp) begin failures++; $display("FAIL alu_op%0d got=%b exp=%b", i, ctl, exp); end
            tick();
        end
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== IDLE) begin failures++; $display("FAIL alu_state got=%0d exp=%0d", state_dbg, IDLE); end
        tick();
    endtask

    task automatic test_branch();
        instr_valid = 1'b1; mode = MODE_BR; opcode = 4'b0100; S_IN = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 11'b0000_00010_00) begin failures++; $display("FAIL branch got=%b exp=%b", ctl, 11'b0000_00010_00); end
        tick();
    endtask

    task automatic test_mem_fast();
        instr_valid = 1'b1; mode = MODE_MEM; S_IN = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 11'b0010_00100_01) begin failures++; $display("FAIL mem_fast got=%b exp=%b", ctl, 11'b0010_00100_01); end
        tick();
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== IDLE) begin failures++; $display("FAIL mem_fast_state got=%0d exp=%0d", state_dbg, IDLE); end
        tick();
    endtask

    task automatic test_mem_wait();
        instr_valid = 1'b1; mode = MODE_MEM; S_IN = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 11'b0010_11000_10) begin failures++; $display("FAIL mem_wait_c%0d got=%b exp=%b", c, ctl, 11'b0010_11000_10); end
            tick();
            // New inputs must be ignored while the access is outstanding.
            instr_valid = 1'b1; mode = MODE_ALU; S_IN = 1'b0; opcode = 4'b1101;
            checks++;
            if (state_dbg !== MEM_WAIT) begin failures++; $display("FAIL mem_wait_state%0d got=%0d exp=%0d", c, state_dbg, MEM_WAIT); end
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({EXE_CMD, writeBackEn, MEM_R_en, MEM_W_en, done} !== 8'b0010_1101) begin
            failures++;
            $display("FAIL mem_wait_done got=%b exp=%b", {EXE_CMD, writeBackEn, MEM_R_en, MEM_W_en, done}, 8'b0010_1101);
        end
        tick();
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== IDLE || ctl !== 11'b0) begin failures++; $display("FAIL mem_wait_exit got=%0d/%b exp=%0d/0", state_dbg, ctl, IDLE); end
        tick();
    endtask

    task automatic test_block_store();
        logic [3:0] exp_x [4];
        logic [6:0] exp_o [4];
        logic [10:0] exp;
        exp_x = '{4'd0, 4'd2, 4'd5, 4'd15};
        exp_o = '{7'd0, 7'd4, 7'd8, 7'd12};
        instr_valid = 1'b1; mode = MODE_BLK; S_IN = 1'b0; reg_list = 16'h8025; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 11'b0000_00000_10) begin failures++; $display("FAIL blk_entry got=%b exp=%b", ctl, 11'b0000_00000_10); end
        tick();
        instr_valid = 1'b1; mode = MODE_BLK; S_IN = 1'b1; reg_list = 16'h00F0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                mem_ready = 1'b0;
                @(negedge clk);
                checks++;
                if ({xfer_reg, addr_offset, ctl} !== {4'd5, 7'd8, 11'b0010_00100_10}) begin
                    failures++;
                    $display("FAIL blk_hold got=%0d/%0d/%b exp=5/8/%b", xfer_reg, addr_offset, ctl, 11'b0010_00100_10);
                end
                tick();
            end
            mem_ready = 1'b1;
            exp = {4'b0010, 5'b00100, 1'b1, (i == 3)};
            @(negedge clk);
            checks++;
            if (xfer_reg !== exp_x[i] || addr_offset !== exp_o[i]) begin
                failures++;
                $display("FAIL blk_beat%0d got=%0d/%0d exp=%0d/%0d", i, xfer_reg, addr_offset, exp_x[i], exp_o[i]);
            end
            checks++;
            if (ctl !== exp) begin failures++; $display("FAIL blk_ctl%0d got=%b exp=%b", i, ctl, exp); end
            tick();
        end
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== IDLE || ctl !== 11'b0) begin failures++; $display("FAIL blk_exit got=%0d/%b exp=%0d/0", state_dbg, ctl, IDLE); end
        tick();
    endtask

    task automatic test_block_empty();
        instr_valid = 1'b1; mode = MODE_BLK; S_IN = 1'b1; reg_list = 16'h0000; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 11'b0000_00000_01) begin failures++; $display("FAIL blk_empty got=%b exp=%b", ctl, 11'b0000_00000_01); end
        tick();
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== IDLE) begin failures++; $display("FAIL blk_empty_state got=%0d exp=%0d", state_dbg, IDLE); end
        tick();
    endtask

    task automatic test_full_mask();
        instr_valid = 1'b1; mode = MODE_BLK; S_IN = 1'b0; reg_list = 16'hFFFF; mem_ready = 1'b0;
        tick();
        instr_valid = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (xfer_reg !== 4'(i) || addr_offset !== 7'(4 * i) || done !== (i == 15)) begin
                failures++;
                $display("FAIL full_beat%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i, xfer_reg, addr_offset, done, i, 4 * i, (i == 15));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (state_dbg !== IDLE || ctl !== 11'b0) begin failures++; $display("FAIL full_exit got=%0d/%b exp=%0d/0", state_dbg, ctl, IDLE); end
        tick();
    endtask

    task automatic test_reset_abort();
        instr_valid = 1'b1; mode = MODE_BLK; S_IN = 1'b1; reg_list = 16'hFFFF; mem_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({xfer_reg, addr_offset, ctl} !== {4'(i), 7'(4 * i), 11'b0010_11000_10}) begin
                failures++;
                $display("FAIL abort_beat%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i, xfer_reg, addr_offset, ctl, i, 4 * i, 11'b0010_11000_10);
            end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({xfer_reg, addr_offset, ctl} !== 22'b0) begin failures++; $display("FAIL abort_outs got=%0d/%0d/%b exp=0/0/0", xfer_reg, addr_offset, ctl); end
        checks++;
        if (state_dbg !== IDLE) begin failures++; $display("FAIL abort_state got=%0d exp=%0d", state_dbg, IDLE); end
        tick();
        rst = 1'b1; instr_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 11'b0) begin failures++; $display("FAIL abort_quiet%0d got=%b exp=%b", c, ctl, 11'b0); end
            tick();
        end
        instr_valid = 1'b1; mode = MODE_ALU; opcode = 4'b0100; S_IN = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 11'b0010_10001_00) begin failures++; $display("FAIL abort_add got=%b exp=%b", ctl, 11'b0010_10001_00); end
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem_fast();
        test_mem_wait();
        test_block_store();
        test_block_empty();
        test_full_mask();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
